// File: rtl/draw_rot_sprite.sv
// Rotated-sprite rasteriser: one framebuffer pixel per clock from quarter-turn ROM frames.
// Optional DRAW_ROT_SPRITE_TRANSPARENCY_EN suppresses writes of the transparent colour.
module draw_rot_sprite #(
    parameter int SPRITE_SIZE  = 32,
    parameter int N_FRAMES     = 6,
    parameter int COLOR_W      = 3,
    parameter int COORD_W      = 10,
    parameter int TRANSP_COLOR = 0,
    localparam int LOG_S   = $clog2(SPRITE_SIZE),
    localparam int FRAME_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1,
    localparam int ADDR_W  = $clog2(N_FRAMES) + 2 * LOG_S
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               plot,
    input  logic [COORD_W-1:0] x_pos,
    input  logic [COORD_W-1:0] y_pos,
    input  logic [FRAME_W-1:0] frame,
    input  logic [1:0]         quadrant,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               busy,
    output logic               done,
    output logic               write_en,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COLOR_W-1:0] color
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAW  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [LOG_S-1:0]   CNT_MAX = LOG_S'(SPRITE_SIZE - 1);
    localparam logic [FRAME_W-1:0] FRAME_MAX = FRAME_W'(N_FRAMES - 1);
    localparam logic [COLOR_W-1:0] TRANSP = COLOR_W'(TRANSP_COLOR);

`ifdef DRAW_ROT_SPRITE_TRANSPARENCY_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    logic [1:0]         state_reg;
    logic               flush_reg;
    logic [LOG_S-1:0]   i_reg;
    logic [LOG_S-1:0]   j_reg;
    logic [COORD_W-1:0] x_pos_reg;
    logic [COORD_W-1:0] y_pos_reg;
    logic [FRAME_W-1:0] frame_reg;
    logic [1:0]         quad_reg;

    logic               s1_valid_reg;
    logic               s1_last_reg;
    logic [LOG_S-1:0]   s1_i_reg;
    logic [LOG_S-1:0]   s1_j_reg;

    logic               write_en_reg;
    logic               done_reg;
    logic [COORD_W-1:0] x_reg;
    logic [COORD_W-1:0] y_reg;
    logic [COLOR_W-1:0] color_reg;

    logic [FRAME_W-1:0] frame_clamped;
    logic [LOG_S-1:0]   src_c;
    logic [LOG_S-1:0]   src_r;
    logic [FRAME_W+2*LOG_S-1:0] addr_full;
    logic               opaque;

    assign frame_clamped = (int'(frame) >= N_FRAMES) ? FRAME_MAX : frame;

    // S-1-n is the bitwise complement of n because S is a power of two.
    always_comb begin
        src_c = i_reg;
        src_r = j_reg;
        case (quad_reg)
            2'd0: begin src_c = i_reg;  src_r = j_reg;  end
            2'd1: begin src_c = j_reg;  src_r = ~i_reg; end
            2'd2: begin src_c = ~i_reg; src_r = ~j_reg; end
            2'd3: begin src_c = ~j_reg; src_r = i_reg;  end
            default: begin src_c = i_reg; src_r = j_reg; end
        endcase
    end

    // frame*S^2 + r*S + c is a plain concatenation for power-of-two S.
    assign addr_full = {frame_reg, src_r, src_c};
    assign rom_addr  = (state_reg == ST_DRAW) ? addr_full[ADDR_W-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            flush_reg <= 1'b0;
            i_reg     <= '0;
            j_reg     <= '0;
            x_pos_reg <= '0;
            y_pos_reg <= '0;
            frame_reg <= '0;
            quad_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (plot) begin
                        x_pos_reg <= x_pos;
                        y_pos_reg <= y_pos;
                        frame_reg <= frame_clamped;
                        quad_reg  <= quadrant;
                        i_reg     <= '0;
                        j_reg     <= '0;
                        state_reg <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    i_reg <= i_reg + LOG_S'(1);
                    if (i_reg == CNT_MAX) begin
                        j_reg <= j_reg + LOG_S'(1);
                        if (j_reg == CNT_MAX) begin
                            state_reg <= ST_FLUSH;
                            flush_reg <= 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_reg) begin
                        state_reg <= ST_IDLE;
                        flush_reg <= 1'b0;
                    end else begin
                        flush_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Stage 1 tracks the pixel whose address the ROM is registering this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_i_reg     <= '0;
            s1_j_reg     <= '0;
        end else begin
            s1_valid_reg <= (state_reg == ST_DRAW);
            s1_last_reg  <= (state_reg == ST_DRAW) && (i_reg == CNT_MAX) && (j_reg == CNT_MAX);
            s1_i_reg     <= i_reg;
            s1_j_reg     <= j_reg;
        end
    end

    assign opaque = !TRANSP_EN || (rom_data != TRANSP);

    always_ff @(posedge clk) begin
        if (reset) begin
            write_en_reg <= 1'b0;
            done_reg     <= 1'b0;
            x_reg        <= '0;
            y_reg        <= '0;
            color_reg    <= '0;
        end else begin
            write_en_reg <= s1_valid_reg && opaque;
            done_reg     <= s1_valid_reg && s1_last_reg;
            if (s1_valid_reg) begin
                x_reg     <= x_pos_reg + COORD_W'(s1_i_reg);
                y_reg     <= y_pos_reg + COORD_W'(s1_j_reg);
                color_reg <= rom_data;
            end
        end
    end

    assign busy     = (state_reg != ST_IDLE);
    assign done     = done_reg;
    assign write_en = write_en_reg;
    assign x        = x_reg;
    assign y        = y_reg;
    assign color    = color_reg;

endmodule

// File: tb/tb_draw_rot_sprite.sv
// Directed bench for draw_rot_sprite with a 4x4, two-frame sprite and a 2x2, three-frame instance.
module tb_draw_rot_sprite;

    logic       clk;
    logic       reset;
    logic       plot;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [0:0] frame;
    logic [1:0] quadrant;
    logic [4:0] rom_addr;
    logic [4:0] rom_data;
    logic       busy;
    logic       done;
    logic       write_en;
    logic [9:0] x;
    logic [9:0] y;
    logic [4:0] color;

    logic       plot_b;
    logic [1:0] frame_b;
    logic [9:0] zero_pos;
    logic [1:0] quad_b;
    logic [3:0] rom_addr_b;
    logic [4:0] rom_data_b;
    logic       busy_b;
    logic       done_b;
    logic       write_en_b;
    logic [9:0] x_b;
    logic [9:0] y_b;
    logic [4:0] color_b;

    logic [4:0] rom [0:31];

    int n_checks;
    int n_errors;
    int wx [0:15];
    int wy [0:15];
    int wc [0:15];
    int nwr;
    int busy_cyc;
    int done_cnt;
    int done_cyc;
    int done_we;
    int first_cyc;
    int timed_out;
    int stray;

    draw_rot_sprite #(
        .SPRITE_SIZE(4), .N_FRAMES(2), .COLOR_W(5), .COORD_W(10), .TRANSP_COLOR(0)
    ) dut (
        .clk(clk), .reset(reset), .plot(plot), .x_pos(x_pos), .y_pos(y_pos),
        .frame(frame), .quadrant(quadrant), .rom_addr(rom_addr), .rom_data(rom_data),
        .busy(busy), .done(done), .write_en(write_en), .x(x), .y(y), .color(color)
    );

    draw_rot_sprite #(
        .SPRITE_SIZE(2), .N_FRAMES(3), .COLOR_W(5), .COORD_W(10), .TRANSP_COLOR(0)
    ) dut_b (
        .clk(clk), .reset(reset), .plot(plot_b), .x_pos(zero_pos), .y_pos(zero_pos),
        .frame(frame_b), .quadrant(quad_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .busy(busy_b), .done(done_b), .write_en(write_en_b), .x(x_b), .y(y_b), .color(color_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic record_pixel(input int cyc);
        if (nwr < 16) begin
            wx[nwr] = int'(x);
            wy[nwr] = int'(y);
            wc[nwr] = int'(color);
        end
        if (first_cyc < 0) first_cyc = cyc;
        nwr++;
    endtask

    // Cycle index cyc means "sampled at the falling edge after E(cyc)".
    task automatic run_draw(input logic fr, input logic [1:0] q, input logic [9:0] xp,
                            input logic [9:0] yp);
        @(negedge clk);
        frame = fr; quadrant = q; x_pos = xp; y_pos = yp; plot = 1'b1;
        @(posedge clk);
        #1 plot = 1'b0;
        nwr = 0; busy_cyc = 0; done_cnt = 0; done_cyc = -1; done_we = 0;
        first_cyc = -1; timed_out = 1;
        for (int cyc = 0; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (write_en) record_pixel(cyc);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                done_we = int'(write_en);
            end
            if (busy) busy_cyc++;
            else begin
                timed_out = 0;
                break;
            end
        end
        check("draw_timeout", timed_out, 0);
        $display("draw frame=%0d quad=%0d pos=(%0d,%0d): writes=%0d busy=%0d done_cyc=%0d",
                 fr, q, xp, yp, nwr, busy_cyc, done_cyc);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        for (int k = 0; k < 32; k++) rom[k] = 5'(k);
        reset = 1'b1; plot = 1'b0; x_pos = '0; y_pos = '0; frame = '0; quadrant = '0;
        plot_b = 1'b0; frame_b = '0; zero_pos = '0; quad_b = '0; rom_data_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_write_en", int'(write_en), 0);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_color", int'(color), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", int'(busy), 0);

        // Scenario 1: unrotated frame 1 at (10,20).
        run_draw(1'b1, 2'd0, 10'd10, 10'd20);
        check("s1_writes", nwr, 16);
        check("s1_first_cyc", first_cyc, 2);
        check("s1_first_x", wx[0], 10);
        check("s1_first_y", wy[0], 20);
        check("s1_first_color", wc[0], 16);
        check("s1_last_x", wx[15], 13);
        check("s1_last_y", wy[15], 23);
        check("s1_last_color", wc[15], 31);
        check("s1_done_cnt", done_cnt, 1);
        check("s1_done_cyc", done_cyc, 17);
        check("s1_done_with_we", done_we, 1);
        check("s1_busy_cycles", busy_cyc, 18);
        check("s1_mid_color", wc[6], 16 + 4 + 2);

        // Scenario 2: 90 degrees clockwise, frame 0.
        run_draw(1'b0, 2'd1, 10'd0, 10'd0);
        check("s2_writes", nwr, 16);
        check("s2_px00_color", wc[0], 12);
        check("s2_px10_color", wc[1], 8);
        check("s2_px30_color", wc[3], 0);
        check("s2_px30_x", wx[3], 3);
        check("s2_px03_color", wc[12], 15);
        check("s2_px03_y", wy[12], 3);

        // Scenario 3: 180 degrees with x wrapping past 1023.
        run_draw(1'b0, 2'd2, 10'd1022, 10'd0);
        check("s3_x0", wx[0], 1022);
        check("s3_x1", wx[1], 1023);
        check("s3_x2", wx[2], 0);
        check("s3_x3", wx[3], 1);
        check("s3_row1_x", wx[4], 1022);
        check("s3_row1_y", wy[4], 1);
        check("s3_first_color", wc[0], 15);
        check("s3_last_color", wc[15], 0);

        // Scenario 4: second plot mid-draw is ignored, reset aborts after the 5th write.
        @(negedge clk);
        frame = 1'b0; quadrant = 2'd0; x_pos = 10'd5; y_pos = 10'd5; plot = 1'b1;
        @(posedge clk);
        #1 plot = 1'b0;
        nwr = 0; done_cnt = 0; first_cyc = -1;
        for (int cyc = 0; cyc < 40 && nwr < 5; cyc++) begin
            @(negedge clk);
            if (cyc == 3) begin
                plot = 1'b1; frame = 1'b1; quadrant = 2'd3; x_pos = 10'd100; y_pos = 10'd100;
            end else begin
                plot = 1'b0;
            end
            if (write_en) record_pixel(cyc);
            if (done) done_cnt++;
        end
        plot = 1'b0;
        $display("abort draw: writes before reset=%0d", nwr);
        check("s4_writes_before_reset", nwr, 5);
        check("s4_px3_color", wc[3], 3);
        check("s4_px4_x", wx[4], 5);
        check("s4_px4_y", wy[4], 6);
        check("s4_px4_color", wc[4], 4);
        check("s4_done_before_reset", done_cnt, 0);
        reset = 1'b1;
        @(negedge clk);
        check("s4_rst_busy", int'(busy), 0);
        check("s4_rst_done", int'(done), 0);
        check("s4_rst_write_en", int'(write_en), 0);
        check("s4_rst_x", int'(x), 0);
        check("s4_rst_y", int'(y), 0);
        check("s4_rst_color", int'(color), 0);
        check("s4_rst_rom_addr", int'(rom_addr), 0);
        reset = 1'b0;
        stray = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (write_en || done || busy) stray++;
        end
        check("s4_no_activity_after_reset", stray, 0);
        run_draw(1'b1, 2'd0, 10'd0, 10'd0);
        check("s4_redraw_writes", nwr, 16);
        check("s4_redraw_done_cyc", done_cyc, 17);
        check("s4_redraw_last_color", wc[15], 31);

`ifdef DRAW_ROT_SPRITE_TRANSPARENCY_EN
        // Scenario 5: only one opaque texel.
        for (int k = 0; k < 32; k++) rom[k] = 5'd0;
        rom[5] = 5'd7;
        run_draw(1'b0, 2'd0, 10'd0, 10'd0);
        check("s5_writes", nwr, 1);
        check("s5_px_x", wx[0], 1);
        check("s5_px_y", wy[0], 1);
        check("s5_px_color", wc[0], 7);
        check("s5_done_cyc", done_cyc, 17);
        for (int k = 0; k < 32; k++) rom[k] = 5'(k);
`endif

        // Scenario 6: frame index beyond N_FRAMES-1 is clamped (2x2 sprite, 3 frames).
        @(negedge clk);
        frame_b = 2'd3; plot_b = 1'b1;
        @(posedge clk);
        #1 plot_b = 1'b0;
        check("s6_clamp_addr0", int'(rom_addr_b), 8);
        @(posedge clk);
        #1;
        check("s6_clamp_addr1", int'(rom_addr_b), 9);
        $display("clamp draw: frame=3 first addrs 8,9 expected");
        repeat (10) @(negedge clk);
        check("s6_idle_after", int'(busy_b), 0);
        frame_b = 2'd1; plot_b = 1'b1;
        @(posedge clk);
        #1 plot_b = 1'b0;
        check("s6_frame1_addr0", int'(rom_addr_b), 4);
        $display("frame 1 draw on small instance: first addr 4 expected");
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
